nonce_result_scan: RTL and testbench
====================================

Name: nonce_result_scan

Overview:
Reader-side consumer of the hash-output region written by the multi-nonce hasher. After the hasher signals done, this block reads NUM_NONCES consecutive 32-bit hash words from shared memory and compares each against a difficulty target. It reports the smallest hash, its nonce index, and whether that hash is strictly below target. It sits between the hasher and the mining control logic and shares the same single-port memory interface.

Parameters:
NUM_NONCES, 16, number of hash words to scan (legal range 2..256)
IDX_W, $clog2(NUM_NONCES), width of nonce index outputs

Ports:
clk  in  1  system clock; also forwarded as mem_clk
reset  in  1  asynchronous, active-high reset
start  in  1  begin scan; sampled only in IDLE
result_addr  in  16  base address of hash words (word i at result_addr+i)
target  in  32  difficulty target, unsigned
mem_clk  out  1  memory clock, equals clk
mem_we  out  1  memory write enable, constant 0 (read-only block)
mem_addr  out  16  memory read address, registered
mem_read_data  in  32  memory read data
busy  out  1  high from start acceptance until done rises
done  out  1  level; high in DONE until next accepted start
found  out  1  best_hash < target (valid when done=1)
best_nonce  out  IDX_W  index of minimum hash
best_hash  out  32  minimum hash value seen

Behaviour:
- Reset values: mem_addr=0, mem_we=0, busy=0, done=0, found=0, best_nonce=0, best_hash=32'hFFFFFFFF; state=IDLE; all counters 0.
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Memory timing: the memory samples mem_addr on a clk edge, and data is visible for the following cycle. An address registered at edge E is therefore captured by this block at edge E+2.
- States:
  - IDLE: when start=1, register mem_addr<=result_addr, target_q<=target, issue count<=1, best_hash<=FFFFFFFF, best_nonce<=0, found<=0, done<=0, busy<=1, go to READ.
  - READ: each cycle mem_addr<=mem_addr+1 while issue count<NUM_NONCES, incrementing the count. When the count reaches NUM_NONCES, hold mem_addr and go to DRAIN.
  - DRAIN: wait until all NUM_NONCES words are captured, then go to DONE.
  - DONE: done=1, busy=0. start=1 restarts exactly as in IDLE, including clearing done on that edge.
- Capture pipeline: a 2-stage valid/index shift register tracks issued addresses. On each valid capture of word i: if mem_read_data < best_hash (unsigned, strict), then best_hash<=data and best_nonce<=i.
  - Ties keep the lower index.
  - found is registered as (best_hash after update < target_q).
- Latency: with start sampled at edge E0, word i's address is present after E0+i and word i is captured at E0+i+2. Last capture is at E0+NUM_NONCES+1; done rises after E0+NUM_NONCES+2 (after E0+18 for default).
- Address wrap: result_addr+i is computed mod 2^16 (FFFF -> 0000), with no error.
- target is latched at start, so changes to target mid-scan have no effect.
- start while busy is ignored and causes no restart.
- Reset mid-scan returns all outputs to reset values immediately. No partial result is retained.
- target=0: found is always 0. target=FFFFFFFF: found=1 unless every word is FFFFFFFF.
- Outputs best_hash, best_nonce, and found update during the scan. They are only guaranteed when done=1.

Test Plan:
1. All 16 words = 0x80000000+i, target=0x10000000 -> done after E0+18, found=0, best_nonce=0, best_hash=0x80000000.
2. Word 11 = 0x00000ABC, others 0xF0000000, target=0x00001000 -> found=1, best_nonce=11, best_hash=0x00000ABC; mem_addr steps result_addr..result_addr+15, mem_we always 0.
3. Words 3 and 9 both 0x00000005, others larger, target=0x10 -> best_nonce=3 (tie keeps lower index), found=1.
4. result_addr=16'hFFF8 -> addresses FFF8..FFFF then 0000..0007, values read in that order; best_nonce is indexed from 0 at FFF8.
5. Pulse start again at E0+5, and change target mid-scan -> no restart; result uses the latched target. Then start in DONE -> done falls next edge and a new scan runs.
6. Assert reset at E0+7 -> busy=0, done=0, best_hash=FFFFFFFF, mem_addr=0 immediately. A later start produces a correct full scan.

Source files
------------

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES hash words from a registered-read memory and reports the minimum and whether it beats the target.
// Two-stage valid/index pipeline matches the one-cycle memory read latency; results are final when done is high.
module nonce_result_scan #(
  parameter int NUM_NONCES = 16,
  parameter int IDX_W      = $clog2(NUM_NONCES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      result_addr,
  input  logic [31:0]      target,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  input  logic [31:0]      mem_read_data,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] best_nonce,
  output logic [31:0]      best_hash
);

  localparam int              CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NONCES);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [15:0]       mem_addr_q;
  logic [31:0]       target_q;
  logic [CNT_W-1:0]  iss_cnt_q;
  logic [CNT_W-1:0]  cap_cnt_q;
  logic              v0_q, v1_q;
  logic [IDX_W-1:0]  idx0_q, idx1_q;
  logic [31:0]       best_hash_q;
  logic [IDX_W-1:0]  best_nonce_q;
  logic              found_q;
  logic              busy_q;
  logic              done_q;

  logic              take_d;
  logic [31:0]       best_hash_d;

  // Strict compare so equal hashes keep the earlier (lower) index.
  assign take_d      = v1_q && (mem_read_data < best_hash_q);
  assign best_hash_d = take_d ? mem_read_data : best_hash_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_addr_q   <= 16'h0000;
      target_q     <= 32'h0;
      iss_cnt_q    <= '0;
      cap_cnt_q    <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      idx0_q       <= '0;
      idx1_q       <= '0;
      best_hash_q  <= 32'hFFFF_FFFF;
      best_nonce_q <= '0;
      found_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      v0_q   <= 1'b0;
      v1_q   <= v0_q;
      idx1_q <= idx0_q;

      if (v1_q) begin
        cap_cnt_q   <= cap_cnt_q + 1'b1;
        best_hash_q <= best_hash_d;
        found_q     <= (best_hash_d < target_q);
        if (take_d) best_nonce_q <= idx1_q;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mem_addr_q   <= result_addr;
            target_q     <= target;
            iss_cnt_q    <= CNT_W'(1);
            cap_cnt_q    <= '0;
            v0_q         <= 1'b1;
            idx0_q       <= '0;
            best_hash_q  <= 32'hFFFF_FFFF;
            best_nonce_q <= '0;
            found_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= READ;
          end
        end
        READ: begin
          if (iss_cnt_q < LAST) begin
            mem_addr_q <= mem_addr_q + 16'd1;
            iss_cnt_q  <= iss_cnt_q + 1'b1;
            v0_q       <= 1'b1;
            idx0_q     <= iss_cnt_q[IDX_W-1:0];
          end else begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cap_cnt_q == LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_clk    = clk;
  assign mem_we     = 1'b0;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign best_nonce = best_nonce_q;
  assign best_hash  = best_hash_q;

endmodule

// File: tb/tb_nonce_result_scan.sv
// Directed-vector bench for nonce_result_scan with a registered-read memory model.
module tb_nonce_result_scan;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   result_addr;
  logic [31:0]   target;
  logic          mem_clk;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_read_data;
  logic          busy;
  logic          done;
  logic          found;
  logic [IW-1:0] best_nonce;
  logic [31:0]   best_hash;

  logic [31:0] mem [0:65535];
  int n_checks = 0;
  int n_pass   = 0;

  nonce_result_scan #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .result_addr(result_addr), .target(target),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .found(found), .best_nonce(best_nonce), .best_hash(best_hash)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= mem[mem_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] ra, input logic [31:0] val);
    logic [15:0] a;
    for (int i = 0; i < N; i++) begin
      a = 16'(ra + 16'(i));
      mem[a] = val;
    end
  endtask

  // Returns the number of edges after the start edge until done is first seen, or -1.
  task automatic wait_done(input int from, output int lat);
    lat = -1;
    for (int k = from; k <= 40; k++) begin
      tick;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] ra, input logic [31:0] tgt, output int lat);
    result_addr = ra;
    target      = tgt;
    start       = 1'b1;
    tick;
    start = 1'b0;
    wait_done(1, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; result_addr = 16'h0; target = 32'h0;
    tick; tick;
    n_checks++;
    if ({busy, done, found, mem_we, mem_addr, best_nonce, best_hash} !== {4'b0000, 16'h0, 4'h0, 32'hFFFF_FFFF})
      $display("FAIL reset_values: got busy=%b done=%b found=%b we=%b addr=%h nonce=%0d hash=%h",
               busy, done, found, mem_we, mem_addr, best_nonce, best_hash);
    else n_pass++;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    int lat;
    logic [15:0] a;
    for (int i = 0; i < N; i++) begin
      a = 16'(16'h1000 + 16'(i));
      mem[a] = 32'h8000_0000 + 32'(i);
    end
    run_scan(16'h1000, 32'h1000_0000, lat);
    n_checks++;
    if (lat !== 18) $display("FAIL basic_latency: got %0d want 18", lat); else n_pass++;
    n_checks++;
    if ({busy, found, best_nonce, best_hash} !== {1'b0, 1'b0, 4'd0, 32'h8000_0000})
      $display("FAIL basic_result: got busy=%b found=%b nonce=%0d hash=%h want 0 0 0 80000000",
               busy, found, best_nonce, best_hash);
    else n_pass++;
  endtask

  task automatic test_single_min;
    int lat;
    int bad;
    fill(16'h2000, 32'hF000_0000);
    mem[16'h200B] = 32'h0000_0ABC;
    mem[16'h1FFF] = 32'h0;
    mem[16'h2010] = 32'h0;
    result_addr = 16'h2000; target = 32'h0000_1000; start = 1'b1;
    tick;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if ({mem_we, mem_addr} !== {1'b0, 16'(16'h2000 + 16'(i))}) bad++;
      tick;
    end
    n_checks++;
    if (bad != 0) $display("FAIL addr_walk: %0d cycles with wrong addr or we set, want 0", bad); else n_pass++;
    wait_done(17, lat);
    n_checks++;
    if (lat !== 18) $display("FAIL single_latency: got %0d want 18", lat); else n_pass++;
    n_checks++;
    if ({found, best_nonce, best_hash} !== {1'b1, 4'd11, 32'h0000_0ABC})
      $display("FAIL single_result: got found=%b nonce=%0d hash=%h want 1 11 00000abc", found, best_nonce, best_hash);
    else n_pass++;
    n_checks++;
    if ({mem_we, mem_addr} !== {1'b0, 16'h200F})
      $display("FAIL addr_hold: got we=%b addr=%h want 0 200f", mem_we, mem_addr);
    else n_pass++;
  endtask

  task automatic test_tie;
    int lat;
    fill(16'h3000, 32'h0000_0100);
    mem[16'h3003] = 32'h5;
    mem[16'h3009] = 32'h5;
    run_scan(16'h3000, 32'h10, lat);
    n_checks++;
    if ({found, best_nonce, best_hash} !== {1'b1, 4'd3, 32'h5})
      $display("FAIL tie_lower_index: got found=%b nonce=%0d hash=%h want 1 3 5", found, best_nonce, best_hash);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int lat;
    int bad;
    logic [15:0] a;
    for (int i = 0; i < N; i++) begin
      a = 16'(16'hFFF8 + 16'(i));
      mem[a] = 32'h5000_0000 + 32'(i);
    end
    mem[16'h0002] = 32'h0000_0123;
    mem[16'hFFF7] = 32'h1;
    mem[16'h0008] = 32'h1;
    result_addr = 16'hFFF8; target = 32'h200; start = 1'b1;
    tick;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (mem_addr !== 16'(16'hFFF8 + 16'(i))) bad++;
      tick;
    end
    n_checks++;
    if (bad != 0) $display("FAIL wrap_addr: %0d cycles with wrong addr, want 0", bad); else n_pass++;
    wait_done(17, lat);
    n_checks++;
    if ({lat == 18, found, best_nonce, best_hash} !== {1'b1, 1'b1, 4'd10, 32'h0000_0123})
      $display("FAIL wrap_result: got lat=%0d found=%b nonce=%0d hash=%h want 18 1 10 00000123",
               lat, found, best_nonce, best_hash);
    else n_pass++;
  endtask

  task automatic test_restart;
    int lat;
    fill(16'h4000, 32'h0000_0900);
    mem[16'h4006] = 32'h0000_0800;
    result_addr = 16'h4000; target = 32'h0000_1000; start = 1'b1;
    tick;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) target = 32'h0;
      start = (k == 5);
      tick;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 18) $display("FAIL ignore_start_latency: got %0d want 18", lat); else n_pass++;
    n_checks++;
    if ({found, best_nonce, best_hash} !== {1'b1, 4'd6, 32'h0000_0800})
      $display("FAIL latched_target: got found=%b nonce=%0d hash=%h want 1 6 00000800", found, best_nonce, best_hash);
    else n_pass++;
    mem[16'h400C] = 32'h0000_0700;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b01) $display("FAIL restart_from_done: got done=%b busy=%b want 0 1", done, busy);
    else n_pass++;
    wait_done(1, lat);
    n_checks++;
    if ({lat == 18, found, best_nonce, best_hash} !== {1'b1, 1'b0, 4'd12, 32'h0000_0700})
      $display("FAIL restart_result: got lat=%0d found=%b nonce=%0d hash=%h want 18 0 12 00000700",
               lat, found, best_nonce, best_hash);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [15:0] a;
    for (int i = 0; i < N; i++) begin
      a = 16'(16'h5000 + 16'(i));
      mem[a] = 32'h10 + 32'(i);
    end
    result_addr = 16'h5000; target = 32'h20; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) tick;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, found, mem_addr, best_nonce, best_hash} !== {3'b000, 16'h0, 4'd0, 32'hFFFF_FFFF})
      $display("FAIL reset_mid_scan: got busy=%b done=%b found=%b addr=%h nonce=%0d hash=%h",
               busy, done, found, mem_addr, best_nonce, best_hash);
    else n_pass++;
    tick;
    reset = 1'b0;
    tick;
    run_scan(16'h5000, 32'h20, lat);
    n_checks++;
    if ({lat == 18, found, best_nonce, best_hash} !== {1'b1, 1'b1, 4'd0, 32'h10})
      $display("FAIL post_reset_scan: got lat=%0d found=%b nonce=%0d hash=%h want 18 1 0 00000010",
               lat, found, best_nonce, best_hash);
    else n_pass++;
  endtask

  task automatic test_target_max;
    int lat;
    fill(16'h6000, 32'hFFFF_FFFF);
    run_scan(16'h6000, 32'hFFFF_FFFF, lat);
    n_checks++;
    if ({found, best_nonce, best_hash} !== {1'b0, 4'd0, 32'hFFFF_FFFF})
      $display("FAIL all_ones: got found=%b nonce=%0d hash=%h want 0 0 ffffffff", found, best_nonce, best_hash);
    else n_pass++;
    mem[16'h600F] = 32'hFFFF_FFFE;
    run_scan(16'h6000, 32'hFFFF_FFFF, lat);
    n_checks++;
    if ({found, best_nonce, best_hash} !== {1'b1, 4'd15, 32'hFFFF_FFFE})
      $display("FAIL last_word_min: got found=%b nonce=%0d hash=%h want 1 15 fffffffe", found, best_nonce, best_hash);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'hDEAD_BEEF;
    test_reset;
    test_basic;
    test_single_min;
    test_tie;
    test_wrap;
    test_restart;
    test_reset_mid;
    test_target_max;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
